// File: rtl/vga_mode_switch_ctrl.sv
// vga_mode_switch_ctrl: sequences a VGA resolution change (drain frame, blank, reclock, settle, re-enable).
// Resolution code: 0=640x480 1=800x600 2=1024x768 3=1280x1024. Define VGA_MODE_SWITCH_BOOT_EN to configure DEFAULT_RES at boot.
module vga_mode_switch_ctrl #(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         MAX_RETRY      = 2,
  parameter int         SETTLE_CYCLES  = 256,
  parameter logic [1:0] DEFAULT_RES    = 2'd1
) (
  input  logic       clk_100m_i,
  input  logic       arstn_i,
  input  logic       req_valid_i,
  input  logic [1:0] req_res_i,
  output logic       req_ready_o,
  input  logic       frame_end_i,
  output logic       disp_en_o,
  output logic       gen_req_o,
  output logic [1:0] gen_res_o,
  input  logic       gen_valid_i,
  output logic [1:0] cur_res_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  typedef enum logic [2:0] {IDLE_S, DRAIN_S, REQ_S, WAIT_VALID_S, SETTLE_S, ERR_S, BOOT_S} state_e;
`ifdef VGA_MODE_SWITCH_BOOT_EN
  localparam state_e RST_STATE = BOOT_S;
  localparam logic   RST_DISP  = 1'b0;
`else
  localparam state_e RST_STATE = IDLE_S;
  localparam logic   RST_DISP  = 1'b1;
`endif
  state_e        state_q, state_d;
  logic          disp_en_q, disp_en_d, err_q, err_d;
  logic [1:0]    gen_res_q, gen_res_d, cur_res_q, cur_res_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] set_q, set_d;
  logic [RW-1:0] retry_q, retry_d;
  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= RST_STATE;
      disp_en_q <= RST_DISP;
      err_q     <= 1'b0;
      gen_res_q <= DEFAULT_RES;
      cur_res_q <= DEFAULT_RES;
      tmo_q     <= '0;
      set_q     <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      disp_en_q <= disp_en_d;
      err_q     <= err_d;
      gen_res_q <= gen_res_d;
      cur_res_q <= cur_res_d;
      tmo_q     <= tmo_d;
      set_q     <= set_d;
      retry_q   <= retry_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    disp_en_d = disp_en_q;
    err_d     = err_q;
    gen_res_d = gen_res_q;
    cur_res_d = cur_res_q;
    tmo_d     = tmo_q;
    set_d     = set_q;
    retry_d   = retry_q;
    case (state_q)
      IDLE_S: if (req_valid_i) begin
        gen_res_d = req_res_i;
        err_d     = 1'b0;
        retry_d   = '0;
        state_d   = DRAIN_S;
      end
      // a display already blanked by a failed attempt has no frame to drain
      DRAIN_S: if (!disp_en_q) state_d = REQ_S;
        else if (frame_end_i) begin
          disp_en_d = 1'b0;
          state_d   = REQ_S;
        end
      REQ_S: begin
        tmo_d   = '0;
        state_d = WAIT_VALID_S;
      end
      WAIT_VALID_S: if (gen_valid_i) begin
        set_d   = '0;
        state_d = SETTLE_S;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        retry_d = (retry_q < RW'(MAX_RETRY)) ? retry_q + RW'(1) : retry_q;
        state_d = (retry_q < RW'(MAX_RETRY)) ? REQ_S : ERR_S;
      end else tmo_d = tmo_q + TW'(1);
      SETTLE_S: if (set_q == SW'(SETTLE_CYCLES)) begin
        cur_res_d = gen_res_q;
        disp_en_d = 1'b1;
        state_d   = IDLE_S;
      end else set_d = set_q + SW'(1);
      ERR_S: begin
        err_d   = 1'b1;
        state_d = IDLE_S;
      end
      BOOT_S: begin
        gen_res_d = DEFAULT_RES;
        disp_en_d = 1'b0;
        err_d     = 1'b0;
        retry_d   = '0;
        state_d   = REQ_S;
      end
      default: state_d = IDLE_S;
    endcase
  end
  assign req_ready_o = state_q == IDLE_S;
  assign busy_o      = state_q != IDLE_S;
  assign gen_req_o   = state_q == REQ_S;
  assign done_o      = (state_q == SETTLE_S) && (set_q == SW'(SETTLE_CYCLES));
  assign disp_en_o   = disp_en_q;
  assign gen_res_o   = gen_res_q;
  assign cur_res_o   = cur_res_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_vga_mode_switch_ctrl.sv
// tb_vga_mode_switch_ctrl: randomized transactions checked against an event-timing model of the switch sequence.
module tb_vga_mode_switch_ctrl;
  localparam int TMO = 100, MR = 2, ST = 16;
  localparam logic [1:0] DEF = 2'd1;
`ifdef VGA_MODE_SWITCH_BOOT_EN
  localparam logic RST_DISP = 1'b0, RST_READY = 1'b0;
`else
  localparam logic RST_DISP = 1'b1, RST_READY = 1'b1;
`endif
  logic clk = 1'b0, arstn = 1'b0, req_valid = 1'b0, frame_end = 1'b0, gen_valid = 1'b0;
  logic [1:0] req_res = 2'd0;
  logic req_ready_o, disp_en_o, gen_req_o, busy_o, done_o, err_o;
  logic [1:0] gen_res_o, cur_res_o;
  int total = 0, bad = 0;
  logic [1:0] m_cur = DEF;
  logic m_disp = 1'b1;
  vga_mode_switch_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR), .SETTLE_CYCLES(ST), .DEFAULT_RES(DEF)) dut (
    .clk_100m_i(clk), .arstn_i(arstn), .req_valid_i(req_valid), .req_res_i(req_res),
    .req_ready_o(req_ready_o), .frame_end_i(frame_end), .disp_en_o(disp_en_o), .gen_req_o(gen_req_o),
    .gen_res_o(gen_res_o), .gen_valid_i(gen_valid), .cur_res_o(cur_res_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o));
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_rst(input string p);
    chk({p, "_disp"}, disp_en_o, RST_DISP);
    chk({p, "_ready"}, req_ready_o, RST_READY);
    chk({p, "_busy"}, busy_o, !RST_READY);
    chk({p, "_genreq"}, gen_req_o, 0);
    chk({p, "_genres"}, gen_res_o, DEF);
    chk({p, "_cur"}, cur_res_o, DEF);
    chk({p, "_done"}, done_o, 0);
    chk({p, "_err"}, err_o, 0);
  endtask
  // Expected timeline in cycles after acceptance: first request, 101-cycle retry spacing, valid, settle.
  task automatic run_txn(input logic [1:0] res, input int fdly, input int ntmo, input int lat,
                         input bit hold, input logic [1:0] nres, input bit boot);
    bit ds, fail;
    int r0, nreq, rl, cv, end_c, fall;
    int q_r[$], q_d[$];
    int disp_b = 0, busy_b = 0, err_b = 0, res_b = 0, cur_b = 0;
    logic [1:0] cur0, cur1;
    ds = !boot && m_disp;
    r0 = boot ? 0 : (ds ? fdly + 1 : 1);
    fail = ntmo > MR;
    nreq = fail ? MR + 1 : ntmo + 1;
    rl = r0 + (nreq - 1) * (TMO + 1);
    cv = rl + lat;
    end_c = fail ? rl + TMO + 2 : cv + ST + 2;
    fall = ds ? fdly + 1 : 0;
    cur0 = m_cur;
    cur1 = fail ? m_cur : res;
    if (!boot) begin
      chk("ready", req_ready_o, 1);
      req_valid = 1'b1;
      req_res = res;
    end
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      if (gen_req_o) q_r.push_back(c);
      if (done_o) q_d.push_back(c);
      if (disp_en_o !== ((c < fall) || (!fail && c == end_c))) disp_b++;
      if (busy_o !== (c < end_c)) busy_b++;
      if (err_o !== (fail && c == end_c)) err_b++;
      if (gen_res_o !== res) res_b++;
      if (cur_res_o !== ((c == end_c) ? cur1 : cur0)) cur_b++;
      if (c < end_c) begin
        req_valid = hold;
        req_res = hold ? nres : 2'($urandom);
        frame_end = (ds && c == fdly) || ((!ds || c > fdly) && $urandom_range(0, 7) == 0);
        gen_valid = (!fail && c == cv) || ((c < r0 || (!fail && c > cv)) && $urandom_range(0, 15) == 0);
      end
    end
    chk("nreq", q_r.size(), nreq);
    for (int i = 0; i < q_r.size() && i < nreq; i++)
      chk($sformatf("req%0d_cyc", i), q_r[i], r0 + i * (TMO + 1));
    chk("ndone", q_d.size(), fail ? 0 : 1);
    if (!fail && q_d.size() > 0) chk("done_cyc", q_d[0], cv + ST + 1);
    chk("disp_trace", disp_b, 0);
    chk("busy_trace", busy_b, 0);
    chk("err_trace", err_b, 0);
    chk("genres_stable", res_b, 0);
    chk("cur_trace", cur_b, 0);
    chk("final_err", err_o, fail);
    chk("final_cur", cur_res_o, cur1);
    chk("final_disp", disp_en_o, !fail);
    m_cur = cur1;
    m_disp = !fail;
  endtask
  task automatic post_reset();
    m_cur = DEF;
    m_disp = 1'b1;
`ifdef VGA_MODE_SWITCH_BOOT_EN
    run_txn(DEF, 0, 0, 20, 1'b0, 2'd0, 1'b1);
`else
    @(negedge clk);
    gen_valid = 1'b0;
    @(negedge clk);
    chk("post_busy", busy_o, 0);
    chk("post_genreq", gen_req_o, 0);
    chk("post_cur", cur_res_o, DEF);
    chk("post_disp", disp_en_o, 1);
`endif
  endtask
  initial begin
    logic [1:0] res, nxt;
    bit hold;
    arstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("rst");
    arstn = 1'b1;
    post_reset();
    run_txn(2'd3, 49, 0, 40, 1'b0, 2'd0, 1'b0);
    run_txn(2'd2, 10, 3, 1, 1'b0, 2'd0, 1'b0);
    run_txn(2'd0, 5, 0, 25, 1'b0, 2'd0, 1'b0);
    run_txn(2'd2, 7, 1, 30, 1'b0, 2'd0, 1'b0);
    run_txn(2'd1, 0, 0, TMO, 1'b0, 2'd0, 1'b0);
    run_txn(2'd3, 12, 0, 10, 1'b1, 2'd0, 1'b0);
    run_txn(2'd0, 3, 0, 5, 1'b0, 2'd0, 1'b0);
    // abort mid-wait with an asynchronous reset
    frame_end = 1'b0;
    gen_valid = 1'b0;
    chk("t5_ready", req_ready_o, 1);
    req_valid = 1'b1;
    req_res = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    for (int n = 0; n < 20 && !gen_req_o; n++) @(negedge clk);
    chk("t5_req", gen_req_o, 1);
    repeat (5) @(negedge clk);
    #2 arstn = 1'b0;
    #1 chk_rst("arst");
`ifndef VGA_MODE_SWITCH_BOOT_EN
    gen_valid = 1'b1;
`endif
    @(negedge clk);
    arstn = 1'b1;
    post_reset();
    nxt = 2'($urandom);
    for (int t = 0; t < 20; t++) begin
      res = nxt;
      nxt = 2'($urandom);
      hold = (t < 19) && ($urandom_range(0, 3) == 0);
      run_txn(res, $urandom_range(0, 20),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, MR + 1) : 0,
              $urandom_range(1, TMO), hold, nxt, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
